// File: rtl/mmio_led_pwm_if.sv
// mmio_led_pwm_if: core MMIO output bus (address + data) snooped by the LED PWM block
interface mmio_led_pwm_if;
  logic [15:0] mmio_out_addr;
  logic [7:0]  mmio_out;
  modport master (output mmio_out_addr, output mmio_out);
  modport slave  (input mmio_out_addr, input mmio_out);
endinterface

// File: rtl/mmio_led_pwm.sv
// mmio_led_pwm: MMIO-snooping multi-channel LED driver with 8-bit PWM and static/blink/one-shot modes
module mmio_led_pwm #(
  parameter int          CHANNELS   = 6,
  parameter logic [15:0] BASE_ADDR  = 16'hF000,
  parameter int          PRESCALE   = 105,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  mmio_led_pwm_if.slave       bus,
  output logic [CHANNELS-1:0] led
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic [PW-1:0]       presc;
  logic [7:0]          pwm_cnt;
  logic [15:0]         frame_cnt;
  logic                enable;
  logic                step, period_end, bus_live, ctrl_wr;
  logic [CHANNELS-1:0] lit;
  assign step       = presc == PW'(PRESCALE - 1);
  assign period_end = step && pwm_cnt == 8'hFF;
  assign bus_live   = bus.mmio_out_addr != 16'h0000;
  assign ctrl_wr    = bus_live && bus.mmio_out_addr == BASE_ADDR + 16'(2 * CHANNELS);
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc     <= '0;
      pwm_cnt   <= '0;
      frame_cnt <= '0;
      enable    <= 1'b1;
      led       <= {CHANNELS{ACTIVE_LOW}};
    end else begin
      presc     <= step ? '0 : presc + 1'b1;
      pwm_cnt   <= step ? pwm_cnt + 8'd1 : pwm_cnt;
      frame_cnt <= period_end ? frame_cnt + 16'd1 : frame_cnt;
      enable    <= ctrl_wr ? bus.mmio_out[0] : enable;
      led       <= lit ^ {CHANNELS{ACTIVE_LOW}};
    end
  end
  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    logic [7:0]  duty, active_duty;
    logic [4:0]  mode;
    logic [15:0] timer;
    logic        duty_wr, mode_wr, gate, pwm_on;
    assign duty_wr = bus_live && bus.mmio_out_addr == BASE_ADDR + 16'(2 * k);
    assign mode_wr = bus_live && bus.mmio_out_addr == BASE_ADDR + 16'(2 * k + 1);
    // active_duty samples the pre-write DUTY on a coincident period end
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        duty        <= '0;
        mode        <= '0;
        active_duty <= '0;
        timer       <= '0;
      end else begin
        duty        <= duty_wr ? bus.mmio_out : duty;
        mode        <= mode_wr ? bus.mmio_out[4:0] : mode;
        active_duty <= period_end ? duty : active_duty;
        if (mode_wr)
          timer <= bus.mmio_out[1:0] == 2'b10 ? 16'd8 << bus.mmio_out[4:2] : 16'd0;
        else if (period_end && timer != 16'd0)
          timer <= timer - 16'd1;
      end
    end
    always_comb begin
      pwm_on = active_duty == 8'hFF || pwm_cnt < active_duty;
      gate   = mode[1:0] == 2'b01 ? frame_cnt[{1'b0, mode[4:2]} + 4'd3] :
               mode[1:0] == 2'b10 ? timer != 16'd0 : 1'b1;
    end
    assign lit[k] = pwm_on && gate && enable;
  end
endmodule

// File: tb/tb_mmio_led_pwm.sv
// tb_mmio_led_pwm: directed self-checking bench; PRESCALE=2 gives 512-cycle PWM periods
module tb_mmio_led_pwm;
  localparam int          CH   = 6;
  localparam logic [15:0] BASE = 16'hF000;
  localparam logic [15:0] CTRL = BASE + 16'(2 * CH);
  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [CH-1:0] led;
  int            cyc;
  int            n_cmp = 0;
  int            n_fail = 0;
  mmio_led_pwm_if bus();
  mmio_led_pwm #(.CHANNELS(CH), .BASE_ADDR(BASE), .PRESCALE(2), .ACTIVE_LOW(1'b1)) dut (
    .clock(clock), .reset(reset), .bus(bus.slave), .led(led));
  always #5 clock = ~clock;
  // cyc mirrors the DUT's edge count since reset, so cyc % 512 == 0 marks a period boundary
  always @(posedge clock or posedge reset)
    if (reset) cyc <= 0;
    else cyc <= cyc + 1;

  task automatic wr(input logic [15:0] a, input logic [7:0] d, input int n);
    bus.mmio_out_addr = a;
    bus.mmio_out      = d;
    repeat (n) @(negedge clock);
    bus.mmio_out_addr = 16'h0000;
  endtask

  task automatic align(input int p);
    @(negedge clock);
    while (cyc % 512 != p) @(negedge clock);
  endtask

  task automatic count_win(input int ch, input int wr_at, input logic [15:0] a,
                           input logic [7:0] d, output int c);
    c = 0;
    for (int i = 0; i < 512; i++) begin
      @(negedge clock);
      if (led[ch] === 1'b0) c++;
      if (i == wr_at) begin
        bus.mmio_out_addr = a;
        bus.mmio_out      = d;
      end else bus.mmio_out_addr = 16'h0000;
    end
  endtask

  task automatic test_reset();
    int bad;
    bus.mmio_out_addr = 16'h0000;
    bus.mmio_out      = 8'h00;
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (led !== 6'h3F) begin n_fail++; $display("FAIL reset_async: got %b expected %b", led, 6'h3F); end
    repeat (3) @(negedge clock);
    reset = 1'b0;
    bad = 0;
    repeat (2048) begin
      @(negedge clock);
      if (led !== 6'h3F) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin n_fail++; $display("FAIL reset_idle: got %0d lit samples expected 0", bad); end
  endtask

  task automatic test_duty();
    int c;
    align(100);
    wr(BASE, 8'd64, 1);
    align(0);
    count_win(0, -1, 16'h0, 8'h0, c);
    n_cmp++;
    if (c !== 128) begin n_fail++; $display("FAIL duty64: got %0d expected 128", c); end
  endtask

  task automatic test_shadow();
    int c;
    count_win(0, 200, BASE, 8'd200, c);
    n_cmp++;
    if (c !== 128) begin n_fail++; $display("FAIL shadow_old: got %0d expected 128", c); end
    count_win(0, -1, 16'h0, 8'h0, c);
    n_cmp++;
    if (c !== 400) begin n_fail++; $display("FAIL shadow_new: got %0d expected 400", c); end
  endtask

  task automatic test_boundary();
    int c;
    count_win(0, 510, BASE, 8'd0, c);
    n_cmp++;
    if (c !== 400) begin n_fail++; $display("FAIL bnd_cur: got %0d expected 400", c); end
    count_win(0, -1, 16'h0, 8'h0, c);
    n_cmp++;
    if (c !== 400) begin n_fail++; $display("FAIL bnd_old: got %0d expected 400", c); end
    count_win(0, 100, BASE, 8'd255, c);
    n_cmp++;
    if (c !== 0) begin n_fail++; $display("FAIL duty0: got %0d expected 0", c); end
    count_win(0, -1, 16'h0, 8'h0, c);
    n_cmp++;
    if (c !== 512) begin n_fail++; $display("FAIL duty255: got %0d expected 512", c); end
  endtask

  task automatic test_blink();
    int c, w, e;
    align(50);
    wr(BASE + 16'd5, 8'h01, 1);
    wr(BASE + 16'd4, 8'd255, 1);
    align(0);
    for (int i = 0; i < 12; i++) begin
      w = cyc / 512;
      e = ((w >> 3) & 1) != 0 ? 512 : 0;
      count_win(2, -1, 16'h0, 8'h0, c);
      n_cmp++;
      if (c !== e) begin n_fail++; $display("FAIL blink_w%0d: got %0d expected %0d", w, c, e); end
    end
  endtask

  task automatic test_oneshot();
    int c, s;
    align(50);
    wr(BASE + 16'd2, 8'd255, 1);
    align(10);
    wr(BASE + 16'd3, 8'h06, 3);
    align(0);
    s = 0;
    for (int i = 0; i < 15; i++) begin
      count_win(1, -1, 16'h0, 8'h0, c);
      s += c;
    end
    n_cmp++;
    if (s !== 15 * 512) begin n_fail++; $display("FAIL oneshot_on: got %0d expected %0d", s, 15 * 512); end
    count_win(1, -1, 16'h0, 8'h0, c);
    n_cmp++;
    if (c !== 0) begin n_fail++; $display("FAIL oneshot_expire: got %0d expected 0", c); end
    count_win(1, -1, 16'h0, 8'h0, c);
    n_cmp++;
    if (c !== 0) begin n_fail++; $display("FAIL oneshot_hold: got %0d expected 0", c); end
    align(10);
    wr(BASE + 16'd3, 8'h06, 3);
    align(0);
    count_win(1, -1, 16'h0, 8'h0, c);
    n_cmp++;
    if (c !== 512) begin n_fail++; $display("FAIL oneshot_relight: got %0d expected 512", c); end
  endtask

  task automatic test_ctrl();
    align(50);
    for (int k = 0; k < CH; k++) begin
      wr(BASE + 16'(2 * k), 8'd255, 1);
      wr(BASE + 16'(2 * k + 1), 8'h00, 1);
    end
    align(0);
    @(negedge clock);
    n_cmp++;
    if (led !== 6'h00) begin n_fail++; $display("FAIL all_lit: got %b expected %b", led, 6'h00); end
    wr(CTRL, 8'h00, 1);
    n_cmp++;
    if (led !== 6'h00) begin n_fail++; $display("FAIL ctrl_latency: got %b expected %b", led, 6'h00); end
    @(negedge clock);
    n_cmp++;
    if (led !== 6'h3F) begin n_fail++; $display("FAIL ctrl_off: got %b expected %b", led, 6'h3F); end
    wr(CTRL + 16'd1, 8'h01, 1);
    wr(16'h0000, 8'h01, 2);
    repeat (3) @(negedge clock);
    n_cmp++;
    if (led !== 6'h3F) begin n_fail++; $display("FAIL unmapped: got %b expected %b", led, 6'h3F); end
    wr(CTRL, 8'h01, 1);
    @(negedge clock);
    n_cmp++;
    if (led !== 6'h00) begin n_fail++; $display("FAIL ctrl_on: got %b expected %b", led, 6'h00); end
  endtask

  task automatic test_reset_midop();
    int bad;
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (led !== 6'h3F) begin n_fail++; $display("FAIL midop_reset: got %b expected %b", led, 6'h3F); end
    @(negedge clock);
    reset = 1'b0;
    bad = 0;
    repeat (600) begin
      @(negedge clock);
      if (led !== 6'h3F) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin n_fail++; $display("FAIL midop_cleared: got %0d lit samples expected 0", bad); end
  endtask

  initial begin
    test_reset();
    test_duty();
    test_shadow();
    test_boundary();
    test_blink();
    test_oneshot();
    test_ctrl();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
